// File: rtl/reorder_buffer_if.sv
// Handshake bundle between the ID/ROB stage, execution writeback and the ROB.
// master = pipeline side, slave = reorder buffer.
interface reorder_buffer_if #(
  parameter int ROB_IDX_WIDTH = 3,
  parameter int EXC_WIDTH     = 8
);
  logic                     flush;
  logic                     alloc_en;
  logic                     reg_write_en_in;
  logic [4:0]               reg_write_addr_in;
  logic [EXC_WIDTH-1:0]     exception_type_in;
  logic                     is_delayslot_in;
  logic [31:0]              pc_in;
  logic [ROB_IDX_WIDTH-1:0] alloc_idx;
  logic                     rob_full;
  logic                     wb_en;
  logic [ROB_IDX_WIDTH-1:0] wb_idx;
  logic [31:0]              wb_data;
  logic                     commit_en;
  logic                     commit_reg_write_en;
  logic [4:0]               commit_reg_write_addr;
  logic [31:0]              commit_data;
  logic [31:0]              commit_pc;
  logic [EXC_WIDTH-1:0]     commit_exception_type;
  logic                     commit_is_delayslot;
  logic [ROB_IDX_WIDTH-1:0] commit_idx;

  modport master (
    output flush, alloc_en, reg_write_en_in, reg_write_addr_in, exception_type_in,
           is_delayslot_in, pc_in, wb_en, wb_idx, wb_data,
    input  alloc_idx, rob_full, commit_en, commit_reg_write_en, commit_reg_write_addr,
           commit_data, commit_pc, commit_exception_type, commit_is_delayslot, commit_idx
  );

  modport slave (
    input  flush, alloc_en, reg_write_en_in, reg_write_addr_in, exception_type_in,
           is_delayslot_in, pc_in, wb_en, wb_idx, wb_data,
    output alloc_idx, rob_full, commit_en, commit_reg_write_en, commit_reg_write_addr,
           commit_data, commit_pc, commit_exception_type, commit_is_delayslot, commit_idx
  );
endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocate at tail, out-of-order writeback,
// retire one done entry per cycle from head.
module reorder_buffer #(
  parameter int ROB_DEPTH     = 8,
  parameter int ROB_IDX_WIDTH = 3,
  parameter int EXC_WIDTH     = 8
) (
  input  logic             clk,
  input  logic             rst,
  reorder_buffer_if.slave  rob
);
  localparam int PW = ROB_IDX_WIDTH + 1;

  logic [PW-1:0]                          r_head, r_tail;
  logic [PW-1:0]                          w_count;
  logic [ROB_IDX_WIDTH-1:0]               w_head_idx, w_tail_idx;
  logic                                   w_full, w_alloc, w_commit;

  logic [ROB_DEPTH-1:0]                   r_valid, r_done, r_we, r_dly;
  logic [ROB_DEPTH-1:0][31:0]             r_data, r_pc;
  logic [ROB_DEPTH-1:0][4:0]              r_rd;
  logic [ROB_DEPTH-1:0][EXC_WIDTH-1:0]    r_exc;

  assign w_head_idx = r_head[ROB_IDX_WIDTH-1:0];
  assign w_tail_idx = r_tail[ROB_IDX_WIDTH-1:0];
  assign w_count    = r_tail - r_head;
  assign w_full     = (w_count == PW'(ROB_DEPTH));
  // Both decisions use pre-edge state, so a commit never frees a slot for the same edge.
  assign w_alloc    = rob.alloc_en && !w_full;
  assign w_commit   = r_valid[w_head_idx] && r_done[w_head_idx];

  assign rob.rob_full  = w_full;
  assign rob.alloc_idx = w_tail_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
    end else if (rob.flush) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_alloc)  r_tail <= r_tail + PW'(1);
      if (w_commit) r_head <= r_head + PW'(1);
    end
  end

  // A non-full tail slot is always invalid, so alloc and wb never collide on one entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_done  <= '0;
      r_we    <= '0;
      r_dly   <= '0;
      r_data  <= '0;
      r_pc    <= '0;
      r_rd    <= '0;
      r_exc   <= '0;
    end else if (rob.flush) begin
      r_valid <= '0;
      r_done  <= '0;
    end else begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        if (w_commit && w_head_idx == ROB_IDX_WIDTH'(i))
          r_valid[i] <= 1'b0;
        if (rob.wb_en && rob.wb_idx == ROB_IDX_WIDTH'(i) && r_valid[i]) begin
          r_done[i] <= 1'b1;
          r_data[i] <= rob.wb_data;
        end
        if (w_alloc && w_tail_idx == ROB_IDX_WIDTH'(i)) begin
          r_valid[i] <= 1'b1;
          r_done[i]  <= |rob.exception_type_in;
          r_data[i]  <= '0;
          r_we[i]    <= rob.reg_write_en_in;
          r_rd[i]    <= rob.reg_write_addr_in;
          r_exc[i]   <= rob.exception_type_in;
          r_dly[i]   <= rob.is_delayslot_in;
          r_pc[i]    <= rob.pc_in;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rob.commit_en             <= 1'b0;
      rob.commit_reg_write_en   <= 1'b0;
      rob.commit_reg_write_addr <= '0;
      rob.commit_data           <= '0;
      rob.commit_pc             <= '0;
      rob.commit_exception_type <= '0;
      rob.commit_is_delayslot   <= 1'b0;
      rob.commit_idx            <= '0;
    end else if (rob.flush) begin
      rob.commit_en <= 1'b0;
    end else begin
      rob.commit_en <= w_commit;
      if (w_commit) begin
        rob.commit_reg_write_en   <= r_we[w_head_idx];
        rob.commit_reg_write_addr <= r_rd[w_head_idx];
        rob.commit_data           <= r_data[w_head_idx];
        rob.commit_pc             <= r_pc[w_head_idx];
        rob.commit_exception_type <= r_exc[w_head_idx];
        rob.commit_is_delayslot   <= r_dly[w_head_idx];
        rob.commit_idx            <= w_head_idx;
      end
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Reorder buffer bench: directed vector table, corner-case sequences and a
// random phase, all checked against an in-order scoreboard queue.
module tb_reorder_buffer;
  localparam int D = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reorder_buffer_if #(.ROB_IDX_WIDTH(3), .EXC_WIDTH(8)) rif ();
  reorder_buffer #(.ROB_DEPTH(D), .ROB_IDX_WIDTH(3), .EXC_WIDTH(8)) dut (
    .clk (clk), .rst (rst), .rob (rif.slave)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          idx;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        we;
    logic [7:0]  exc;
    logic        dly;
    logic        done;
    logic [31:0] data;
  } ent_t;

  ent_t q[$];
  int   m_tail = 0;
  bit   m_cen  = 0;
  ent_t m_c;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_tail = 0;
    m_cen  = 0;
  endtask

  // One clock: drive, advance model, sample 1ns after the edge, compare.
  task automatic step(input bit a, input logic [31:0] pc, input logic [4:0] rd, input bit we,
                      input logic [7:0] exc, input bit dly, input bit wb, input int wbi,
                      input logic [31:0] wbd, input bit fl);
    bit full;
    ent_t e;
    rif.alloc_en = a; rif.pc_in = pc; rif.reg_write_addr_in = rd; rif.reg_write_en_in = we;
    rif.exception_type_in = exc; rif.is_delayslot_in = dly;
    rif.wb_en = wb; rif.wb_idx = 3'(wbi); rif.wb_data = wbd; rif.flush = fl;
    @(posedge clk);
    full = (q.size() == D);
    if (fl) begin
      model_reset();
    end else begin
      m_cen = (q.size() > 0) && q[0].done;
      if (m_cen) m_c = q[0];
      if (wb) foreach (q[i]) if (q[i].idx == wbi) begin q[i].done = 1; q[i].data = wbd; end
      if (m_cen) void'(q.pop_front());
      if (a && !full) begin
        e.idx = m_tail; e.pc = pc; e.rd = rd; e.we = we; e.exc = exc; e.dly = dly;
        e.done = (exc != 0); e.data = 0;
        q.push_back(e);
        m_tail = (m_tail + 1) % D;
      end
    end
    #1;
    chk("rob_full", rif.rob_full, q.size() == D);
    chk("alloc_idx", rif.alloc_idx, m_tail);
    chk("commit_en", rif.commit_en, m_cen);
    if (m_cen) begin
      chk("commit_pc", rif.commit_pc, m_c.pc);
      chk("commit_data", rif.commit_data, m_c.data);
      chk("commit_rd", rif.commit_reg_write_addr, m_c.rd);
      chk("commit_we", rif.commit_reg_write_en, m_c.we);
      chk("commit_exc", rif.commit_exception_type, m_c.exc);
      chk("commit_dly", rif.commit_is_delayslot, m_c.dly);
      chk("commit_idx", rif.commit_idx, m_c.idx);
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic alloc(input logic [31:0] pc);
    step(1, pc, 5'(pc[6:2]), 1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wb(input int i, input logic [31:0] d);
    step(0, 0, 0, 0, 0, 0, 1, i, d, 0);
  endtask

  typedef struct {
    bit a; logic [31:0] pc; logic [4:0] rd; logic [7:0] exc;
    bit wb; int wbi; logic [31:0] wbd;
    bit full; int aidx; bit cen; logic [31:0] cpc; logic [31:0] cdata; logic [7:0] cexc;
  } vec_t;

  vec_t vt[15];

  initial begin
    // Expected outputs after each edge, derived by hand.
    vt[0]  = '{1, 32'h100, 5, 0, 0, 0, 0,            0, 1, 0, 32'h0,   32'h0,        8'h0};
    vt[1]  = '{0, 0,       0, 0, 1, 0, 32'hDEADBEEF, 0, 1, 0, 32'h0,   32'h0,        8'h0};
    vt[2]  = '{0, 0,       0, 0, 0, 0, 0,            0, 1, 1, 32'h100, 32'hDEADBEEF, 8'h0};
    vt[3]  = '{1, 32'h200, 1, 0, 0, 0, 0,            0, 2, 0, 32'h100, 32'hDEADBEEF, 8'h0};
    vt[4]  = '{1, 32'h204, 2, 0, 0, 0, 0,            0, 3, 0, 32'h100, 32'hDEADBEEF, 8'h0};
    vt[5]  = '{1, 32'h208, 3, 0, 0, 0, 0,            0, 4, 0, 32'h100, 32'hDEADBEEF, 8'h0};
    vt[6]  = '{0, 0,       0, 0, 1, 3, 32'h3,        0, 4, 0, 32'h100, 32'hDEADBEEF, 8'h0};
    vt[7]  = '{0, 0,       0, 0, 1, 2, 32'h2,        0, 4, 0, 32'h100, 32'hDEADBEEF, 8'h0};
    vt[8]  = '{0, 0,       0, 0, 1, 1, 32'h1,        0, 4, 0, 32'h100, 32'hDEADBEEF, 8'h0};
    vt[9]  = '{0, 0,       0, 0, 0, 0, 0,            0, 4, 1, 32'h200, 32'h1,        8'h0};
    vt[10] = '{0, 0,       0, 0, 0, 0, 0,            0, 4, 1, 32'h204, 32'h2,        8'h0};
    vt[11] = '{0, 0,       0, 0, 0, 0, 0,            0, 4, 1, 32'h208, 32'h3,        8'h0};
    vt[12] = '{0, 0,       0, 0, 0, 0, 0,            0, 4, 0, 32'h208, 32'h3,        8'h0};
    vt[13] = '{1, 32'h300, 7, 8'h04, 0, 0, 0,        0, 5, 0, 32'h208, 32'h3,        8'h0};
    vt[14] = '{0, 0,       0, 0, 0, 0, 0,            0, 5, 1, 32'h300, 32'h0,        8'h04};

    rif.flush = 0; rif.alloc_en = 0; rif.reg_write_en_in = 0; rif.reg_write_addr_in = 0;
    rif.exception_type_in = 0; rif.is_delayslot_in = 0; rif.pc_in = 0;
    rif.wb_en = 0; rif.wb_idx = 0; rif.wb_data = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_full", rif.rob_full, 0);
    chk("rst_aidx", rif.alloc_idx, 0);
    chk("rst_cen", rif.commit_en, 0);
    chk("rst_cpc", rif.commit_pc, 0);
    chk("rst_cdata", rif.commit_data, 0);
    rst = 0;

    for (int i = 0; i < 15; i++) begin
      step(vt[i].a, vt[i].pc, vt[i].rd, 1, vt[i].exc, 0, vt[i].wb, vt[i].wbi, vt[i].wbd, 0);
      chk($sformatf("vec%0d_full", i), rif.rob_full, vt[i].full);
      chk($sformatf("vec%0d_aidx", i), rif.alloc_idx, vt[i].aidx);
      chk($sformatf("vec%0d_cen", i), rif.commit_en, vt[i].cen);
      chk($sformatf("vec%0d_cpc", i), rif.commit_pc, vt[i].cpc);
      chk($sformatf("vec%0d_cdata", i), rif.commit_data, vt[i].cdata);
      chk($sformatf("vec%0d_cexc", i), rif.commit_exception_type, vt[i].cexc);
    end

    // Asynchronous reset with entries in flight.
    alloc(32'h400);
    alloc(32'h404);
    rst = 1;
    #1;
    chk("arst_aidx", rif.alloc_idx, 0);
    chk("arst_full", rif.rob_full, 0);
    chk("arst_cen", rif.commit_en, 0);
    chk("arst_cpc", rif.commit_pc, 0);
    model_reset();
    @(negedge clk);
    rst = 0;

    // Fill, overflow attempt, then alloc+wb+commit while full.
    for (int i = 0; i < D; i++) alloc(32'h1000 + 32'(i * 4));
    chk("fill_full", rif.rob_full, 1);
    alloc(32'h2000);
    chk("over_aidx", rif.alloc_idx, 0);
    chk("over_full", rif.rob_full, 1);
    wb(0, 32'hA0);
    chk("full_wb_full", rif.rob_full, 1);
    step(1, 32'h2004, 9, 1, 0, 0, 1, 1, 32'hA1, 0);
    chk("tri_cen", rif.commit_en, 1);
    chk("tri_cpc", rif.commit_pc, 32'h1000);
    chk("tri_full", rif.rob_full, 0);
    chk("tri_count7", q.size(), 7);
    chk("tri_aidx", rif.alloc_idx, 0);
    alloc(32'h2008);
    chk("wrap_aidx", rif.alloc_idx, 1);
    idle();

    // Flush with concurrent alloc and wb.
    model_reset();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) alloc(32'h3000 + 32'(i * 4));
    wb(0, 32'h55);
    step(1, 32'h3100, 1, 1, 0, 0, 1, 1, 32'h66, 1);
    chk("flush_cen", rif.commit_en, 0);
    chk("flush_full", rif.rob_full, 0);
    chk("flush_aidx", rif.alloc_idx, 0);
    idle();
    chk("flush_cen2", rif.commit_en, 0);

    for (int c = 0; c < 400; c++) begin
      step($urandom_range(0, 2) != 0, $urandom, 5'($urandom), 1'($urandom),
           ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'h0, 1'($urandom),
           $urandom_range(0, 2) != 0, $urandom_range(0, D - 1), $urandom,
           $urandom_range(0, 59) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
